vend_dispenser: RTL and testbench

//  Output-side companion of the vending FSM. Consumes its one-cycle dispense

---
 rtl/vend_dispenser_pkg.sv | 31 +++
 rtl/vend_dispenser_if.sv | 29 ++
 rtl/vend_dispenser_fifo.sv | 55 +++++
 rtl/vend_dispenser.sv | 132 +++++++++++++
 tb/tb_vend_dispenser.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vend_dispenser_pkg.sv
// Shared change codes, FSM state encoding and queue entry layout for the
// vending dispenser.
package vend_dispenser_pkg;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_ONE  = 2'b01;
    localparam logic [1:0] CHG_TWO  = 2'b10;
    localparam logic [1:0] CHG_BAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOTOR     = 3'd1,
        ST_KICK      = 3'd2,
        ST_WAIT_COIN = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    typedef struct packed {
        logic       vend;
        logic [1:0] chg;
    } evt_t;

    function automatic logic [1:0] chg_coins(input logic [1:0] chg);
        case (chg)
            CHG_ONE: return 2'd1;
            CHG_TWO: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_dispenser_if.sv
// Event/actuator bundle between the vending controller side and the dispenser.
interface vend_dispenser_if #(
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH + 1);

    logic          vend;
    logic [1:0]    change;
    logic          coin_sensed;
    logic          fault_clr;
    logic          motor_on;
    logic          hopper_kick;
    logic          busy;
    logic          fault;
    logic          overflow;
    logic          bad_code;
    logic [PW-1:0] pending;

    modport master (
        output vend, change, coin_sensed, fault_clr,
        input  motor_on, hopper_kick, busy, fault, overflow, bad_code, pending
    );

    modport slave (
        input  vend, change, coin_sensed, fault_clr,
        output motor_on, hopper_kick, busy, fault, overflow, bad_code, pending
    );

endinterface

// File: rtl/vend_dispenser_fifo.sv
// Small synchronous FIFO for vend events; pointers and count reset
// asynchronously, storage is left unreset.
module vend_dispenser_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    // A push into a full queue is legal only alongside a pop; the head is read
    // before the write lands, so the shared slot is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/vend_dispenser.sv
// Queues vend events and sequences the product motor and coin-return hopper,
// confirming every returned coin against the hopper exit sensor.
module vend_dispenser
    import vend_dispenser_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int MOTOR_CYC    = 8,
    parameter int COIN_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    vend_dispenser_if.slave  bus
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int MW = (MOTOR_CYC > 1) ? $clog2(MOTOR_CYC) : 1;
    localparam int TW = (COIN_TIMEOUT > 1) ? $clog2(COIN_TIMEOUT) : 1;

    state_e        state_q;
    logic [MW-1:0] mcnt_q;
    logic [TW-1:0] tmr_q;
    logic [1:0]    coins_q;
    logic          overflow_q;
    logic          bad_q;

    evt_t          evt_d;
    evt_t          head;
    logic          push_req_d;
    logic          push_d;
    logic          pop_d;
    logic          full;
    logic          empty;
    logic [PW-1:0] count;

    // An invalid code still dispenses if vend is set, but never returns coins.
    always_comb begin
        evt_d.vend = bus.vend;
        evt_d.chg  = (bus.change == CHG_BAD) ? CHG_NONE : bus.change;
        push_req_d = bus.vend || (bus.change == CHG_ONE) || (bus.change == CHG_TWO);
    end

    assign pop_d  = (state_q == ST_IDLE) && !empty;
    assign push_d = push_req_d && (!full || pop_d);

    vend_dispenser_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(evt_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_d),
        .pop_i   (pop_d),
        .wdata_i (evt_d),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Sticky flags: a new event in the same cycle as fault_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            if (bus.fault_clr) begin
                overflow_q <= 1'b0;
                bad_q      <= 1'b0;
            end
            if (push_req_d && !push_d) overflow_q <= 1'b1;
            if (bus.change == CHG_BAD) bad_q      <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mcnt_q  <= '0;
            tmr_q   <= '0;
            coins_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        coins_q <= chg_coins(head.chg);
                        if (head.vend) begin
                            state_q <= ST_MOTOR;
                            mcnt_q  <= MW'(MOTOR_CYC - 1);
                        end else if (chg_coins(head.chg) != 2'd0) begin
                            state_q <= ST_KICK;
                        end
                    end
                end
                ST_MOTOR: begin
                    if (mcnt_q == '0)
                        state_q <= (coins_q != 2'd0) ? ST_KICK : ST_IDLE;
                    else
                        mcnt_q <= mcnt_q - 1'b1;
                end
                ST_KICK: begin
                    tmr_q   <= TW'(COIN_TIMEOUT - 1);
                    state_q <= ST_WAIT_COIN;
                end
                ST_WAIT_COIN: begin
                    if (bus.coin_sensed) begin
                        coins_q <= coins_q - 2'd1;
                        state_q <= (coins_q > 2'd1) ? ST_KICK : ST_IDLE;
                    end else if (tmr_q == '0) begin
                        state_q <= ST_FAULT;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (bus.fault_clr) begin
                        state_q <= ST_IDLE;
                        coins_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.motor_on    = (state_q == ST_MOTOR);
    assign bus.hopper_kick = (state_q == ST_KICK);
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.busy        = (state_q != ST_IDLE) || !empty;
    assign bus.overflow    = overflow_q;
    assign bus.bad_code    = bad_q;
    assign bus.pending     = count;

endmodule

// File: tb/tb_vend_dispenser.sv
// Scoreboard bench: each driven event queues its expected motor runs and
// kicks; a negedge monitor pops and compares them as the DUT produces them.
module tb_vend_dispenser;
    import vend_dispenser_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MCYC     = 8;
    localparam int CTO      = 16;
    localparam int EV_KICK  = 1;
    localparam int EV_MOTOR = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vend_dispenser_if #(.DEPTH(DEPTH)) vif ();

    vend_dispenser #(
        .DEPTH        (DEPTH),
        .MOTOR_CYC    (MCYC),
        .COIN_TIMEOUT (CTO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    bit coin_auto = 1'b1;
    int cdown = 0;
    int run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input int got);
        if (exp_q.size() == 0) chk("sb_unexpected_event", got, 0);
        else                   chk("sb_event", got, exp_q.pop_front());
    endtask

    function automatic int n_coins(input logic [1:0] c);
        return (c == CHG_ONE) ? 1 : (c == CHG_TWO) ? 2 : 0;
    endfunction

    task automatic drive(input logic v, input logic [1:0] c, input bit drop);
        vif.vend   = v;
        vif.change = c;
        if (!drop) begin
            if (v) exp_q.push_back(EV_MOTOR + MCYC);
            for (int i = 0; i < n_coins(c); i++) exp_q.push_back(EV_KICK);
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        vif.vend   = 1'b0;
        vif.change = CHG_NONE;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (vif.busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, vif.busy, 0);
        @(negedge clk);
        chk({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    // Hopper model: one sensor pulse three cycles after each kick.
    initial begin
        vif.coin_sensed = 1'b0;
        forever begin
            @(negedge clk);
            vif.coin_sensed = 1'b0;
            if (cdown > 0) begin
                cdown--;
                if (cdown == 0) vif.coin_sensed = 1'b1;
            end
            if (vif.hopper_kick && coin_auto) cdown = 3;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (vif.motor_on) run++;
                else if (run > 0) begin
                    sb_pop(EV_MOTOR + run);
                    run = 0;
                end
                if (vif.hopper_kick) sb_pop(EV_KICK);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vif.vend      = 1'b0;
        vif.change    = CHG_NONE;
        vif.fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {vif.motor_on, vif.hopper_kick, vif.busy, vif.fault,
                            vif.overflow, vif.bad_code, vif.pending}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single vend, no change
        drive(1'b1, CHG_NONE, 1'b0);
        idle_in();
        chk("t1_pending_after_push", vif.pending, 1);
        chk("t1_motor_before_pop", vif.motor_on, 0);
        @(negedge clk);
        chk("t1_motor_start", vif.motor_on, 1);
        wait_idle("t1");

        // 2: vend with two coins of change
        drive(1'b1, CHG_TWO, 1'b0);
        idle_in();
        wait_idle("t2");
        chk("t2_fault", vif.fault, 0);
        chk("t2_pending", vif.pending, 0);

        // 3: change only
        drive(1'b0, CHG_ONE, 1'b0);
        idle_in();
        wait_idle("t3");

        // 4: six back-to-back vends overflow a 4-deep queue
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, CHG_NONE, (i == 5));
            if (i == 4) chk("t4_pending_peak", vif.pending, DEPTH);
        end
        idle_in();
        chk("t4_overflow", vif.overflow, 1);
        chk("t4_pending_full", vif.pending, DEPTH);
        wait_idle("t4");
        vif.fault_clr = 1'b1;
        @(negedge clk);
        vif.fault_clr = 1'b0;
        chk("t4_overflow_cleared", vif.overflow, 0);

        // 5: missing coin -> fault, events queue during fault
        coin_auto = 1'b0;
        drive(1'b0, CHG_ONE, 1'b0);
        idle_in();
        k = 0;
        while (!vif.hopper_kick && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5_kick_seen", vif.hopper_kick, 1);
        repeat (CTO) @(negedge clk);
        chk("t5_no_fault_yet", vif.fault, 0);
        @(negedge clk);
        chk("t5_fault", vif.fault, 1);
        drive(1'b1, CHG_NONE, 1'b0);
        drive(1'b1, CHG_NONE, 1'b0);
        idle_in();
        chk("t5_pending_in_fault", vif.pending, 2);
        chk("t5_motor_in_fault", vif.motor_on, 0);
        coin_auto = 1'b1;
        vif.fault_clr = 1'b1;
        @(negedge clk);
        vif.fault_clr = 1'b0;
        chk("t5_fault_cleared", vif.fault, 0);
        wait_idle("t5");

        // 6: reset in the middle of a motor run, then an invalid change code
        drive(1'b1, CHG_NONE, 1'b0);
        drive(1'b1, CHG_NONE, 1'b0);
        idle_in();
        repeat (3) @(negedge clk);
        chk("t6_motor_running", vif.motor_on, 1);
        chk("t6_pending_queued", vif.pending, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_motor_async_drop", vif.motor_on, 0);
        chk("t6_pending_reset", vif.pending, 0);
        @(negedge clk);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(1'b1, CHG_BAD, 1'b0);
        idle_in();
        chk("t6_bad_code", vif.bad_code, 1);
        chk("t6_pending_bad", vif.pending, 1);
        wait_idle("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
